// File: rtl/ram_pkg.sv
// ----------------------------------------------------------------------------
// ram_pkg
// Shared types and constants for the dual-port byte-enable RAM (ram_dp_be).
//   state_t  : init-sweep sequencer states (ST_INIT, ST_RUN)
//   SEG_DEF  : default byte-lane width in bits
// ----------------------------------------------------------------------------
package ram_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int SEG_DEF = 8;

endpackage

// File: rtl/ram_dp_be_if.sv
// ----------------------------------------------------------------------------
// ram_dp_be_if
// Bus bundle for ram_dp_be: write port, read port and ready status.
//   master : drives i_wr_* / i_rd_*, observes o_rd_data, o_rd_valid, o_ready
//   slave  : the RAM side (opposite directions)
// Parameters BREITE (data width), TIEFE (address width), SEG (lane width).
// ----------------------------------------------------------------------------
interface ram_dp_be_if
   import ram_pkg::*;
#(
   parameter int BREITE = 16,
   parameter int TIEFE  = 8,
   parameter int SEG    = SEG_DEF
);
   localparam int NSEG = BREITE / SEG;

   logic              i_wr_en;
   logic [TIEFE-1:0]  i_wr_addr;
   logic [NSEG-1:0]   i_wr_be;
   logic [BREITE-1:0] i_wr_data;
   logic              i_rd_en;
   logic [TIEFE-1:0]  i_rd_addr;
   logic [BREITE-1:0] o_rd_data;
   logic              o_rd_valid;
   logic              o_ready;

   modport master (
      output i_wr_en, i_wr_addr, i_wr_be, i_wr_data, i_rd_en, i_rd_addr,
      input  o_rd_data, o_rd_valid, o_ready
   );

   modport slave (
      input  i_wr_en, i_wr_addr, i_wr_be, i_wr_data, i_rd_en, i_rd_addr,
      output o_rd_data, o_rd_valid, o_ready
   );
endinterface

// File: rtl/ram_clear_seq.sv
// ----------------------------------------------------------------------------
// ram_clear_seq
// Post-reset clearing sequencer: walks every address once, then parks in RUN.
//   i_clk        clock (posedge)
//   i_rst_n      asynchronous active-low reset; restarts the sweep at address 0
//   o_init_addr  address being cleared this cycle
//   o_init_we    1 while the sweep writes (whole word, all lanes)
//   o_ready      registered; 1 from the cycle after the last word is cleared
// ----------------------------------------------------------------------------
module ram_clear_seq
   import ram_pkg::*;
#(
   parameter int TIEFE = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   output logic [TIEFE-1:0] o_init_addr,
   output logic             o_init_we,
   output logic             o_ready
);

   state_t         r_state;
   logic [TIEFE:0] r_cnt;
   logic           r_ready;
   logic [TIEFE:0] w_cnt_next;

   // One extra counter bit: its MSB going high marks the final word written,
   // so the counter never wraps back onto address 0.
   assign w_cnt_next = r_cnt + {{TIEFE{1'b0}}, 1'b1};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
         r_ready <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_cnt <= w_cnt_next;
               if (w_cnt_next[TIEFE]) begin
                  r_state <= ST_RUN;
                  r_ready <= 1'b1;
               end
            end
            ST_RUN:  r_state <= ST_RUN;
            default: r_state <= ST_INIT;
         endcase
      end
   end

   assign o_init_addr = r_cnt[TIEFE-1:0];
   assign o_init_we   = (r_state == ST_INIT);
   assign o_ready     = r_ready;

endmodule

// File: rtl/ram_dp_be.sv
// ----------------------------------------------------------------------------
// ram_dp_be
// Simple dual-port synchronous RAM with byte-lane write enables, registered
// read (latency 1) with valid strobe, and a clearing sweep after reset.
//   i_clk    clock (posedge)
//   i_rst_n  asynchronous active-low reset (memory contents are not reset)
//   io_bus   ram_dp_be_if.slave: write port, read port, o_ready
// Build option: define RAM_BYPASS_EN for write-first behaviour on a
// same-address same-cycle read/write; otherwise reads are read-first.
// ----------------------------------------------------------------------------
module ram_dp_be
   import ram_pkg::*;
#(
   parameter int                 BREITE    = 16,
   parameter int                 TIEFE     = 8,
   parameter int                 SEG       = SEG_DEF,
   parameter logic [BREITE-1:0]  INIT_WERT = '0
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   ram_dp_be_if.slave  io_bus
);

   localparam int NSEG  = BREITE / SEG;
   localparam int DEPTH = 1 << TIEFE;

   logic [BREITE-1:0] r_mem [DEPTH];
   logic [BREITE-1:0] r_rd_data;
   logic              r_rd_valid;

   logic [TIEFE-1:0]  w_init_addr;
   logic              w_init_we;
   logic              w_ready;
   logic              w_user_we;
   logic              w_rd_fire;
   logic [TIEFE-1:0]  w_wr_addr;
   logic [BREITE-1:0] w_wr_data;
   logic [NSEG-1:0]   w_lane_we;
   logic [BREITE-1:0] w_rd_old;
   logic [BREITE-1:0] w_rd_word;

   ram_clear_seq #(.TIEFE(TIEFE)) u_clear_seq (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .o_init_addr (w_init_addr),
      .o_init_we   (w_init_we),
      .o_ready     (w_ready)
   );

   // User requests are only honoured once the sweep has finished.
   assign w_user_we = w_ready & io_bus.i_wr_en;
   assign w_rd_fire = w_ready & io_bus.i_rd_en;

   assign w_wr_addr = w_init_we ? w_init_addr : io_bus.i_wr_addr;
   assign w_wr_data = w_init_we ? INIT_WERT   : io_bus.i_wr_data;

   generate
      for (genvar gi = 0; gi < NSEG; gi++) begin : g_lane_we
         assign w_lane_we[gi] = w_init_we | (w_user_we & io_bus.i_wr_be[gi]);
      end
   endgenerate

   // Memory array: no reset so it maps onto block RAM.
   always_ff @(posedge i_clk) begin
      for (int k = 0; k < NSEG; k++) begin
         if (w_lane_we[k]) begin
            r_mem[w_wr_addr][k*SEG +: SEG] <= w_wr_data[k*SEG +: SEG];
         end
      end
   end

   assign w_rd_old = r_mem[io_bus.i_rd_addr];

`ifdef RAM_BYPASS_EN
   // Write-first: lanes being written to the address being read are taken
   // from the write data, the rest from the stored word.
   generate
      for (genvar gi = 0; gi < NSEG; gi++) begin : g_bypass
         assign w_rd_word[gi*SEG +: SEG] =
            (w_user_we && io_bus.i_wr_be[gi] && (io_bus.i_wr_addr == io_bus.i_rd_addr))
               ? io_bus.i_wr_data[gi*SEG +: SEG]
               : w_rd_old[gi*SEG +: SEG];
      end
   endgenerate
`else
   assign w_rd_word = w_rd_old;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_fire;
         if (w_rd_fire) begin
            r_rd_data <= w_rd_word;
         end
      end
   end

   assign io_bus.o_rd_data  = r_rd_data;
   assign io_bus.o_rd_valid = r_rd_valid;
   assign io_bus.o_ready    = w_ready;

endmodule

// File: tb/tb_ram_dp_be.sv
// ----------------------------------------------------------------------------
// tb_ram_dp_be
// Directed self-checking bench for ram_dp_be (BREITE=16, TIEFE=4, SEG=8,
// INIT_WERT=16'hA5A5). Honours RAM_BYPASS_EN for the same-address case.
// ----------------------------------------------------------------------------
module tb_ram_dp_be;

   localparam int              BREITE = 16;
   localparam int              TIEFE  = 4;
   localparam int              SEG    = 8;
   localparam logic [15:0]     INITV  = 16'hA5A5;

   logic clk;
   logic rst_n;
   int   n_total;
   int   n_bad;
   logic [15:0] exp_mem [16];

   ram_dp_be_if #(.BREITE(BREITE), .TIEFE(TIEFE), .SEG(SEG)) bus ();

   ram_dp_be #(
      .BREITE    (BREITE),
      .TIEFE     (TIEFE),
      .SEG       (SEG),
      .INIT_WERT (INITV)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                         input logic [1:0] be);
      logic [15:0] r;
      r = old_w;
      if (be[0]) r[7:0]  = new_w[7:0];
      if (be[1]) r[15:8] = new_w[15:8];
      return r;
   endfunction

   // Counts sweep cycles until o_ready, checking no read strobe meanwhile.
   task automatic wait_ready(input string tag);
      int cyc;
      cyc = 0;
      while (!bus.o_ready && cyc < 40) begin
         check({tag, "_valid_in_init"}, {31'b0, bus.o_rd_valid}, 32'd0);
         tick();
         cyc++;
      end
      check({tag, "_sweep_cycles"}, cyc, 32'd16);
   endtask

   task automatic idle_inputs();
      bus.i_wr_en   = 1'b0;
      bus.i_wr_addr = '0;
      bus.i_wr_be   = '0;
      bus.i_wr_data = '0;
      bus.i_rd_en   = 1'b0;
      bus.i_rd_addr = '0;
   endtask

   initial begin
      logic [15:0] wd;
      logic [1:0]  be;
      logic [3:0]  wa;
      logic [3:0]  ra;
      n_total = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      idle_inputs();

      // ---- 1: reset state, sweep length, first read ----
      bus.i_rd_en   = 1'b1;
      bus.i_rd_addr = 4'd3;
      tick();
      tick();
      check("rst_ready", {31'b0, bus.o_ready}, 32'd0);
      check("rst_valid", {31'b0, bus.o_rd_valid}, 32'd0);
      check("rst_data", {16'b0, bus.o_rd_data}, 32'd0);
      rst_n = 1'b1;
      wait_ready("t1");
      check("t1_valid_at_ready", {31'b0, bus.o_rd_valid}, 32'd0);
      tick();
      check("t1_first_valid", {31'b0, bus.o_rd_valid}, 32'd1);
      check("t1_first_data", {16'b0, bus.o_rd_data}, 32'h0000A5A5);
      bus.i_rd_en = 1'b0;

      // ---- 2: full-word write then read ----
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'd2; bus.i_wr_data = 16'h1234; bus.i_wr_be = 2'b11;
      tick();
      bus.i_wr_en = 1'b0;
      bus.i_rd_en = 1'b1; bus.i_rd_addr = 4'd2;
      tick();
      bus.i_rd_en = 1'b0;
      check("t2_valid", {31'b0, bus.o_rd_valid}, 32'd1);
      check("t2_data", {16'b0, bus.o_rd_data}, 32'h00001234);
      tick();
      check("t2_valid_drop", {31'b0, bus.o_rd_valid}, 32'd0);
      check("t2_data_hold", {16'b0, bus.o_rd_data}, 32'h00001234);

      // ---- 3: low-lane-only write ----
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'd5; bus.i_wr_data = 16'hBEEF; bus.i_wr_be = 2'b01;
      tick();
      bus.i_wr_en = 1'b0;
      bus.i_rd_en = 1'b1; bus.i_rd_addr = 4'd5;
      tick();
      bus.i_rd_en = 1'b0;
      check("t3_data", {16'b0, bus.o_rd_data}, 32'h0000A5EF);

      // ---- 4: same-address read/write ----
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'd7; bus.i_wr_data = 16'h00FF; bus.i_wr_be = 2'b11;
      bus.i_rd_en = 1'b1; bus.i_rd_addr = 4'd7;
      tick();
      bus.i_wr_en = 1'b0;
`ifdef RAM_BYPASS_EN
      check("t4_collide", {16'b0, bus.o_rd_data}, 32'h000000FF);
`else
      check("t4_collide", {16'b0, bus.o_rd_data}, 32'h0000A5A5);
`endif
      tick();
      bus.i_rd_en = 1'b0;
      check("t4_reread", {16'b0, bus.o_rd_data}, 32'h000000FF);

      // ---- 5: reset mid-sweep restarts the sweep ----
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'd9; bus.i_wr_data = 16'h1111; bus.i_wr_be = 2'b11;
      tick();
      bus.i_wr_en = 1'b0;
      bus.i_rd_en = 1'b1; bus.i_rd_addr = 4'd9;
      tick();
      bus.i_rd_en = 1'b0;
      check("t5_pre_data", {16'b0, bus.o_rd_data}, 32'h00001111);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_async_ready", {31'b0, bus.o_ready}, 32'd0);
      check("t5_async_data", {16'b0, bus.o_rd_data}, 32'd0);
      tick();
      rst_n = 1'b1;
      repeat (8) tick();
      check("t5_midsweep_ready", {31'b0, bus.o_ready}, 32'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t5_restart_ready", {31'b0, bus.o_ready}, 32'd0);
      // Requests during the sweep must be ignored.
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'd3; bus.i_wr_data = 16'h5555; bus.i_wr_be = 2'b11;
      bus.i_rd_en = 1'b1; bus.i_rd_addr = 4'd0;
      wait_ready("t5");
      idle_inputs();
      for (int i = 0; i < 16; i++) begin
         bus.i_rd_en   = 1'b1;
         bus.i_rd_addr = 4'(i);
         tick();
         check($sformatf("t5_valid_%0d", i), {31'b0, bus.o_rd_valid}, 32'd1);
         check($sformatf("t5_word_%0d", i), {16'b0, bus.o_rd_data}, 32'h0000A5A5);
      end
      bus.i_rd_en = 1'b0;
      for (int i = 0; i < 16; i++) exp_mem[i] = INITV;

      // ---- 6: streaming reads with interleaved writes ----
      for (int i = 0; i < 16; i++) begin
         ra = 4'(i);
         bus.i_rd_en   = 1'b1;
         bus.i_rd_addr = ra;
         bus.i_wr_en   = 1'b0;
         wd = 16'h0;
         be = 2'b00;
         wa = 4'(15 - i);
         if (i % 2 == 0) begin
            wd = 16'(16'h1357 * (i + 1));
            be = (i % 6 == 0) ? 2'b01 : ((i % 6 == 2) ? 2'b10 : 2'b11);
            bus.i_wr_en   = 1'b1;
            bus.i_wr_addr = wa;
            bus.i_wr_data = wd;
            bus.i_wr_be   = be;
         end
         tick();
         check($sformatf("t6_valid_%0d", i), {31'b0, bus.o_rd_valid}, 32'd1);
         check($sformatf("t6_data_%0d", i), {16'b0, bus.o_rd_data}, {16'b0, exp_mem[ra]});
         if (i % 2 == 0) exp_mem[wa] = merge(exp_mem[wa], wd, be);
      end
      idle_inputs();
      tick();
      check("t6_valid_end", {31'b0, bus.o_rd_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
